// File: rtl/apb_pkg.sv
// Shared state encoding and default bus widths for the arbitrated APB master.
package apb_pkg;
    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin arbiter; the last-grant pointer moves only when a grant is taken.
module apb_rr_arbiter
    import apb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req_valid,
    input  logic       i_grant_en,
    output logic       o_winner,
    output logic       o_any_valid
);
    logic r_last;
    logic w_winner;

    // Pointer resets to 1 so requester 0 takes the first tie.
    always_comb begin
        w_winner = i_req_valid[1];
        if (i_req_valid == 2'b11) w_winner = ~r_last;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)           r_last <= 1'b1;
        else if (i_grant_en) r_last <= w_winner;
    end

    assign o_winner    = w_winner;
    assign o_any_valid = |i_req_valid;
endmodule

// File: rtl/apb_arb_master.sv
// APB master serving two local requesters: arbitrates, runs SETUP/ACCESS with a
// bounded PREADY wait, and returns read data or a timeout error to the winner.
module apb_arb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_W,
    parameter int DATA_WIDTH = APB_DATA_W,
    parameter int TIMEOUT    = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic [1:0]              REQ_VALID,
    input  logic [1:0]              REQ_WRITE,
    input  logic [2*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [2*DATA_WIDTH-1:0] REQ_WDATA,
    output logic [1:0]              REQ_ACCEPT,
    output logic [1:0]              RSP_VALID,
    output logic                    RSP_ERR,
    output logic [DATA_WIDTH-1:0]   RSP_RDATA,
    output logic                    BUSY,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY
);
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    apb_state_t r_state, w_state_nxt;
    logic                  r_grant;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_psel, r_penable, r_pwrite, r_rsp_err;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata, r_rsp_rdata;
    logic [1:0]            r_accept, r_rsp_valid;

    logic                  w_psel_nxt, w_penable_nxt, w_grant_en;
    logic                  w_done_ok, w_done_tmo, w_winner, w_any;
    logic [1:0]            w_accept_nxt, w_rsp_valid_nxt;
    logic [1:0][ADDR_WIDTH-1:0] w_req_addr;
    logic [1:0][DATA_WIDTH-1:0] w_req_wdata;

    assign w_req_addr  = REQ_ADDR;
    assign w_req_wdata = REQ_WDATA;

    apb_rr_arbiter u_arb (
        .i_clk       (PCLK),
        .i_rst       (PRESET),
        .i_req_valid (REQ_VALID),
        .i_grant_en  (w_grant_en),
        .o_winner    (w_winner),
        .o_any_valid (w_any)
    );

    // Next-state logic also yields the next value of every registered output,
    // so each output is visible in the same cycle as the state it belongs to.
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_en      = 1'b0;
        w_psel_nxt      = 1'b0;
        w_penable_nxt   = 1'b0;
        w_accept_nxt    = 2'b00;
        w_rsp_valid_nxt = 2'b00;
        w_done_ok       = 1'b0;
        w_done_tmo      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_en             = 1'b1;
                    w_state_nxt            = SETUP;
                    w_psel_nxt             = 1'b1;
                    w_accept_nxt[w_winner] = 1'b1;
                end
            end
            SETUP: begin
                w_state_nxt   = ACCESS;
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
            end
            ACCESS: begin
                if (PREADY) begin
                    w_done_ok                = 1'b1;
                    w_state_nxt              = IDLE;
                    w_rsp_valid_nxt[r_grant] = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_done_tmo               = 1'b1;
                    w_state_nxt              = IDLE;
                    w_rsp_valid_nxt[r_grant] = 1'b1;
                end else begin
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= IDLE;
            r_grant     <= 1'b0;
            r_cnt       <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_accept    <= 2'b00;
            r_rsp_valid <= 2'b00;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_accept    <= w_accept_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            if (w_grant_en) begin
                r_grant  <= w_winner;
                r_pwrite <= REQ_WRITE[w_winner];
                r_paddr  <= w_req_addr[w_winner];
                r_pwdata <= w_req_wdata[w_winner];
            end
            // r_cnt holds the number of ACCESS cycles already completed.
            if (r_state != ACCESS)  r_cnt <= '0;
            else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
            if (w_done_ok) begin
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
            end else if (w_done_tmo) begin
                r_rsp_err   <= 1'b1;
                r_rsp_rdata <= '0;
            end
        end
    end

    assign REQ_ACCEPT = r_accept;
    assign RSP_VALID  = r_rsp_valid;
    assign RSP_ERR    = r_rsp_err;
    assign RSP_RDATA  = r_rsp_rdata;
    assign BUSY       = r_psel;
    assign PSEL       = r_psel;
    assign PENABLE    = r_penable;
    assign PWRITE     = r_pwrite;
    assign PADDR      = r_paddr;
    assign PWDATA     = r_pwdata;
endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: memory-backed slave with programmable wait states,
// transaction-level reference model for grant order, latency and response.
module tb_apb_arb_master;
    localparam int TMO = 16;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [1:0]  REQ_VALID, REQ_WRITE, REQ_ACCEPT, RSP_VALID;
    logic [15:0] REQ_ADDR, REQ_WDATA;
    logic        RSP_ERR, BUSY, PSEL, PENABLE, PWRITE, PREADY;
    logic [7:0]  RSP_RDATA, PADDR, PWDATA, PRDATA;

    apb_arb_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .REQ_ACCEPT(REQ_ACCEPT), .RSP_VALID(RSP_VALID), .RSP_ERR(RSP_ERR), .RSP_RDATA(RSP_RDATA),
        .BUSY(BUSY), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    // Slave: PREADY rises after wait_n stalled ACCESS cycles; force_rdy holds it high always.
    logic [7:0] slv_mem [256];
    int         acc_cnt = 0;
    int         wait_n  = 0;
    bit         force_rdy = 1'b0;
    bit         ovr_en = 1'b0;
    logic [7:0] ovr = 8'h00;

    assign PREADY = force_rdy || (PSEL && PENABLE && (acc_cnt >= wait_n));
    assign PRDATA = ovr_en ? ovr : slv_mem[PADDR];

    always @(posedge PCLK) begin
        if (PSEL && PENABLE) acc_cnt <= acc_cnt + 1;
        else                 acc_cnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE) slv_mem[PADDR] <= PWDATA;
    end

    // Reference model state
    logic [7:0] model_mem [256];
    bit         last = 1'b1;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        REQ_VALID = 2'b00;
        PRESET = 1'b1;
        @(posedge PCLK); @(negedge PCLK);
        chk("rst_ctrl", 32'({PSEL, PENABLE, PWRITE, BUSY, RSP_ERR}), 32'(0));
        chk("rst_paddr", 32'(PADDR), 32'(0));
        chk("rst_pwdata", 32'(PWDATA), 32'(0));
        chk("rst_rdata", 32'(RSP_RDATA), 32'(0));
        chk("rst_accept_rsp", 32'({REQ_ACCEPT, RSP_VALID}), 32'(0));
        PRESET = 1'b0;
        last = 1'b1;
    endtask

    // One complete transfer, entered and left at a negedge with the DUT idle.
    task automatic xfer(input logic [1:0] vld, input logic [1:0] wr,
                        input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input int wt, input bit hold);
        bit g, ok, ew;
        int acc, exp_acc;
        logic [7:0] ea, ed, er;
        logic [1:0] oh;
        g  = (vld == 2'b11) ? !last : vld[1];
        last = g;
        oh = g ? 2'b10 : 2'b01;
        ea = g ? a1 : a0;
        ed = g ? d1 : d0;
        ew = wr[g];
        ok = force_rdy || (wt < TMO);
        exp_acc = force_rdy ? 1 : (ok ? wt + 1 : TMO);
        if (!ok || ew) er = 8'h00;
        else           er = ovr_en ? ovr : model_mem[ea];
        if (ok && ew) model_mem[ea] = ed;

        wait_n    = wt;
        REQ_VALID = vld;
        REQ_WRITE = wr;
        REQ_ADDR  = {a1, a0};
        REQ_WDATA = {d1, d0};
        chk("idle_before_setup", 32'(PSEL), 32'(0));
        @(posedge PCLK); @(negedge PCLK);
        chk("accept", 32'(REQ_ACCEPT), 32'(oh));
        chk("setup_ctrl", 32'({PSEL, PENABLE, BUSY}), 32'(3'b101));
        chk("setup_addr", 32'(PADDR), 32'(ea));
        chk("setup_write", 32'(PWRITE), 32'(ew));
        if (ew) chk("setup_wdata", 32'(PWDATA), 32'(ed));
        chk("setup_no_rsp", 32'(RSP_VALID), 32'(0));
        if (!hold) REQ_VALID = 2'b00;

        acc = 0;
        for (int i = 0; i < TMO + 4; i++) begin
            @(negedge PCLK);
            if (RSP_VALID != 2'b00) break;
            acc++;
            chk("access_ctrl", 32'({PSEL, PENABLE, REQ_ACCEPT}), 32'(4'b1100));
            chk("access_addr", 32'(PADDR), 32'(ea));
        end
        chk("access_cycles", 32'(acc), 32'(exp_acc));
        chk("rsp_valid", 32'(RSP_VALID), 32'(oh));
        chk("rsp_err", 32'(RSP_ERR), 32'(!ok));
        chk("rsp_rdata", 32'(RSP_RDATA), 32'(er));
        chk("rsp_idle", 32'({PSEL, PENABLE, BUSY}), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            slv_mem[i]   = 8'h00;
            model_mem[i] = 8'h00;
        end
        REQ_WRITE = 2'b00; REQ_ADDR = '0; REQ_WDATA = '0;
        do_reset();

        // Write then read back through req0; zero-wait and registered-ready slave
        xfer(2'b01, 2'b01, 8'h05, 8'h00, 8'hA5, 8'h00, 0, 1'b0);
        xfer(2'b01, 2'b00, 8'h05, 8'h00, 8'h00, 8'h00, 1, 1'b0);

        // Reset in IDLE restores the pointer: a 4-deep tie must go 0,1,0,1
        do_reset();
        xfer(2'b11, 2'b11, 8'h10, 8'h20, 8'h11, 8'h21, 0, 1'b1);
        xfer(2'b11, 2'b11, 8'h12, 8'h22, 8'h13, 8'h23, 1, 1'b1);
        xfer(2'b11, 2'b00, 8'h10, 8'h22, 8'h00, 8'h00, 0, 1'b1);
        xfer(2'b11, 2'b00, 8'h12, 8'h20, 8'h00, 8'h00, 2, 1'b0);

        // Slave never ready: timeout after TMO ACCESS cycles, zero read data
        xfer(2'b10, 2'b00, 8'h00, 8'h05, 8'h00, 8'h00, 1000, 1'b0);
        xfer(2'b01, 2'b01, 8'h06, 8'h00, 8'h77, 8'h00, 1000, 1'b0);

        // Ready on the final allowed cycle wins over timeout
        ovr_en = 1'b1; ovr = 8'h3C;
        xfer(2'b01, 2'b00, 8'h07, 8'h00, 8'h00, 8'h00, TMO - 1, 1'b0);
        ovr_en = 1'b0;

        // Stale PREADY high through IDLE and SETUP must not shorten the transfer
        force_rdy = 1'b1;
        xfer(2'b01, 2'b00, 8'h05, 8'h00, 8'h00, 8'h00, 0, 1'b0);
        force_rdy = 1'b0;

        // Reset in the middle of a req1 read: no response, then tie goes to req0
        wait_n = 1000;
        REQ_VALID = 2'b10; REQ_WRITE = 2'b00; REQ_ADDR = {8'h05, 8'h00};
        @(posedge PCLK); @(negedge PCLK);
        chk("mid_accept", 32'(REQ_ACCEPT), 32'(2'b10));
        REQ_VALID = 2'b00;
        @(negedge PCLK);
        chk("mid_access", 32'({PSEL, PENABLE}), 32'(2'b11));
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            chk("mid_no_rsp", 32'({RSP_VALID, PSEL}), 32'(0));
        end
        xfer(2'b11, 2'b00, 8'h05, 8'h06, 8'h00, 8'h00, 0, 1'b0);

        // Req1 alone, three back-to-back reads
        xfer(2'b10, 2'b00, 8'h00, 8'h05, 8'h00, 8'h00, 0, 1'b0);
        xfer(2'b10, 2'b00, 8'h00, 8'h06, 8'h00, 8'h00, 1, 1'b0);
        xfer(2'b10, 2'b00, 8'h00, 8'h10, 8'h00, 8'h00, 3, 1'b0);

        // Randomized mix of requesters, directions and wait states
        for (int n = 0; n < 24; n++) begin
            int r, wt;
            r = int'($urandom_range(0, 9));
            if (r == 0)      wt = TMO + 5;
            else if (r == 1) wt = TMO - 1;
            else             wt = int'($urandom_range(0, 3));
            xfer(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                 8'($urandom), 8'($urandom), wt, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_arb_master.md
# apb_arb_master

Two-requester APB master that arbitrates between two local request ports and sequences the APB SETUP/ACCESS phases toward a single `APB_Slave`-style peripheral. It latches the winning request and drives `PSEL`/`PENABLE`/`PADDR`/`PWRITE`/`PWDATA`. It waits on `PREADY` with a bounded timeout and returns read data or an error to the granted requester. It sits between the local bus clients and the peripheral bus.

## Interface
- `ADDR_WIDTH`, 8, APB address width
- `DATA_WIDTH`, 8, APB data width
- `TIMEOUT`, 16, max ACCESS cycles without `PREADY` before abort (≥1)

Ports:
- `PCLK`  in  1  the single clock for the block; all logic on rising edge
- `PRESET`  in  1  synchronous, active-high reset
- `REQ_VALID`  in  2  per-requester request valid; held until `REQ_ACCEPT` seen
- `REQ_WRITE`  in  2  per-requester 1=write, 0=read
- `REQ_ADDR`  in  2*ADDR_WIDTH  requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `REQ_WDATA`  in  2*DATA_WIDTH  requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `REQ_ACCEPT`  out  2  one-cycle pulse, request captured
- `RSP_VALID`  out  2  one-cycle pulse, transfer finished for requester i
- `RSP_ERR`  out  1  qualifies `RSP_VALID`; 1 = timeout
- `RSP_RDATA`  out  DATA_WIDTH  read data, shared; valid with `RSP_VALID`
- `BUSY`  out  1  high in SETUP and ACCESS
- `PSEL`, `PENABLE`, `PWRITE`  out  1 each  APB control
- `PADDR`  out  ADDR_WIDTH  APB address
- `PWDATA`  out  DATA_WIDTH  APB write data
- `PRDATA`  in  DATA_WIDTH  APB read data
- `PREADY`  in  1  APB ready

## Operation
- FSM states:
  - IDLE
    - `PSEL` = 0, `PENABLE` = 0.
    - If any `REQ_VALID`: the arbiter picks a winner, and the winner's write/addr/wdata go into the transfer registers.
    - Grant register ← winner, then → SETUP.
  - SETUP
    - `PSEL` = 1, `PENABLE` = 0, `REQ_ACCEPT[grant]` = 1, timeout counter cleared.
    - → ACCESS unconditionally.
  - ACCESS
    - `PSEL` = 1, `PENABLE` = 1, counter increments each cycle.
    - `PREADY` = 1: capture `PRDATA` into `RSP_RDATA` (reads only; writes load 0), `RSP_ERR` ← 0, pulse `RSP_VALID[grant]`, → IDLE.
    - Else, if this is the TIMEOUT-th ACCESS cycle: `RSP_RDATA` ← 0, `RSP_ERR` ← 1, pulse `RSP_VALID[grant]`, → IDLE.
- Arbitration: 2-way round robin on a last-grant pointer.
  - One valid: that requester wins.
  - Both valid: the requester not granted last wins.
  - The pointer updates only on grant. Its reset value makes requester 0 win the first tie.
- `PREADY` is sampled only in ACCESS. It is ignored in IDLE and SETUP, where a stale high from the previous transfer is legal.
- `PREADY` high on the TIMEOUT-th cycle counts as success; success has priority over timeout.
- `PADDR`/`PWRITE`/`PWDATA` hold stable from SETUP through the last ACCESS cycle, and keep their last value in IDLE.
- Counter width is $clog2(TIMEOUT+1). It saturates and does not wrap.
- Reset (`PRESET` = 1 at an edge, any state):
  - Next cycle: IDLE; pointer at its reset value.
  - Outputs all 0: `PSEL`, `PENABLE`, `PWRITE`, `PADDR`, `PWDATA`, `REQ_ACCEPT`, `RSP_VALID`, `RSP_ERR`, `RSP_RDATA`, `BUSY`.
  - An in-flight transfer is dropped with no `RSP_VALID`.

## Timing
- All outputs are registered; no combinational input→output paths.
- Request capture edge = E0: SETUP and `REQ_ACCEPT` during E0–E1, ACCESS from E1.
- Zero-wait slave (`PREADY` high in the first ACCESS cycle): `RSP_VALID` high in the cycle after E2, i.e. 3 cycles after capture.
- Registered-`PREADY` slave (`APB_Slave` behaviour, ready one cycle into ACCESS): `RSP_VALID` 4 cycles after capture.
- Back-to-back: at least one IDLE cycle between transfers. The new capture edge coincides with the `RSP_VALID` cycle's end.
- A requester must drop or update `REQ_VALID` after the edge where `REQ_ACCEPT` is high. Its next request is not sampled until IDLE.

## Structure
- Shared package `apb_pkg`:
  - state enum `apb_state_t` {IDLE, SETUP, ACCESS}
  - default `ADDR_WIDTH`/`DATA_WIDTH` constants
- Sub-module `apb_rr_arbiter`:
  - 2-way round-robin winner selection plus last-grant pointer
  - inputs: `REQ_VALID`, grant-enable
  - outputs: winner index, any-valid
- Top holds the FSM, transfer registers, timeout counter and response logic. It is simulated against the existing `APB_Slave`.

## Test plan
- Req0 write addr 0x05 data 0xA5, then req0 read 0x05 → `PSEL`/`PENABLE` SETUP→ACCESS sequence correct; each `RSP_VALID[0]` has `RSP_ERR` = 0; read `RSP_RDATA` = 0xA5.
- Both `REQ_VALID` held high for 4 transfers from reset → `REQ_ACCEPT` order 0,1,0,1.
- Slave model holds `PREADY` = 0 → exactly 16 ACCESS cycles, then `RSP_VALID[g]` = 1, `RSP_ERR` = 1, `RSP_RDATA` = 0x00; `PSEL` = 0 the following cycle.
- `PREADY` first high on the 16th ACCESS cycle, `PRDATA` = 0x3C → `RSP_ERR` = 0, `RSP_RDATA` = 0x3C.
- `PRESET` pulsed during ACCESS of a req1 read → next cycle every output 0, no `RSP_VALID`; a following tie grants req0 first.
- Req1 alone issues 3 reads back-to-back → all granted to req1; exactly one IDLE cycle between each `RSP_VALID` and the next SETUP.
